// File: rtl/mips_hold_core.sv
// mips_hold_core
// Multi-cycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq) with local
// instruction and data memories. A HOLD/ACK handshake lets an external DMA
// master take over both memories at an instruction boundary.
//
// Ports:
//   Clock     - single clock, all state changes on the rising edge
//   Reset_n   - asynchronous active-low reset
//   HOLD      - DMA bus request, sampled only in FETCH
//   ACK       - bus granted: core stalled, memories owned by the DMA port
//   DmaSel    - 0 selects instruction memory, 1 selects data memory
//   DmaWe     - DMA write strobe, effective only while ACK=1
//   DmaAddr   - DMA word address (upper bits ignored for the smaller memory)
//   DmaWdata  - DMA write data
//   DmaRdata  - combinational read of the selected memory, 0 when ACK=0
//   PcOut     - current PC (byte address)
//   Retire    - one-cycle pulse when an instruction completes
module mips_hold_core #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    // Derived widths; leave at their defaults.
    parameter int IMEM_AW    = $clog2(IMEM_DEPTH),
    parameter int DMEM_AW    = $clog2(DMEM_DEPTH),
    parameter int DMA_AW     = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              HOLD,
    output logic              ACK,
    input  logic              DmaSel,
    input  logic              DmaWe,
    input  logic [DMA_AW-1:0] DmaAddr,
    input  logic [DATA_W-1:0] DmaWdata,
    output logic [DATA_W-1:0] DmaRdata,
    output logic [31:0]       PcOut,
    output logic              Retire
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HELD
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    // PC wraps at the end of instruction memory.
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] aluOut_q, aluOut_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              retire_q, retire_d;

    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic              regWe;
    logic [4:0]        regWaddr;
    logic [DATA_W-1:0] regWdata;
    logic              storeWe;

    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [DATA_W-1:0] immSext;
    logic [31:0]       branchOff;
    logic [IMEM_AW-1:0] fetchIdx;
    logic [DMEM_AW-1:0] dataIdx;
    logic [IMEM_AW-1:0] dmaImemIdx;
    logic [DMEM_AW-1:0] dmaDmemIdx;

    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign imm       = ir_q[15:0];
    assign immSext   = {{(DATA_W-16){imm[15]}}, imm};
    assign branchOff = {{14{imm[15]}}, imm, 2'b00};
    // Memories are word addressed; byte addresses drop their low two bits.
    assign fetchIdx   = pc_q[IMEM_AW+1:2];
    assign dataIdx    = aluOut_q[DMEM_AW+1:2];
    assign dmaImemIdx = DmaAddr[IMEM_AW-1:0];
    assign dmaDmemIdx = DmaAddr[DMEM_AW-1:0];

    assign ACK    = (state_q == S_HELD);
    assign PcOut  = pc_q;
    assign Retire = retire_q;

    always_comb begin
        DmaRdata = '0;
        if (ACK) begin
            DmaRdata = DmaSel ? dmem[dmaDmemIdx] : imem[dmaImemIdx];
        end
    end

    // Next-state and datapath control. retire_d is raised on every path
    // that returns to FETCH from EXEC, MEM or WB.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluOut_d = aluOut_q;
        mdr_d    = mdr_q;
        retire_d = 1'b0;
        regWe    = 1'b0;
        regWaddr = 5'd0;
        regWdata = '0;
        storeWe  = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (HOLD) begin
                    state_d = S_HELD;
                end else begin
                    ir_d    = imem[fetchIdx][31:0];
                    pc_d    = (pc_q + 32'd4) & PC_MASK;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = (rs == 5'd0) ? '0 : regs[rs];
                b_d     = (rt == 5'd0) ? '0 : regs[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        state_d = S_WB;
                        case (funct)
                            FN_ADD: aluOut_d = a_q + b_q;
                            FN_SUB: aluOut_d = a_q - b_q;
                            FN_AND: aluOut_d = a_q & b_q;
                            FN_OR:  aluOut_d = a_q | b_q;
                            FN_SLT: aluOut_d = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
                            default: begin
                                state_d  = S_FETCH;
                                retire_d = 1'b1;
                            end
                        endcase
                    end
                    OP_LW, OP_SW: begin
                        aluOut_d = a_q + immSext;
                        state_d  = S_MEM;
                    end
                    OP_BEQ: begin
                        // PC already points past the branch here.
                        if (a_q == b_q) begin
                            pc_d = (pc_q + branchOff) & PC_MASK;
                        end
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end
                    default: begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // Only lw and sw reach this state.
                if (opcode == OP_LW) begin
                    mdr_d   = dmem[dataIdx];
                    state_d = S_WB;
                end else begin
                    storeWe  = 1'b1;
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end
            end
            S_WB: begin
                regWe = 1'b1;
                if (opcode == OP_LW) begin
                    regWaddr = rt;
                    regWdata = mdr_q;
                end else begin
                    regWaddr = rd;
                    regWdata = aluOut_q;
                end
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            S_HELD: begin
                if (!HOLD) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluOut_q <= '0;
            mdr_q    <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluOut_q <= aluOut_d;
            mdr_q    <= mdr_d;
            retire_q <= retire_d;
        end
    end

    // Register file; register 0 is never written so it always reads 0.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (regWe && (regWaddr != 5'd0)) begin
            regs[regWaddr] <= regWdata;
        end
    end

    // Memories are not reset. DMA writes are gated by the registered ACK,
    // so the edge that enters HELD and any edge under reset write nothing.
    always_ff @(posedge Clock) begin
        if (ACK && DmaWe) begin
            if (DmaSel) begin
                dmem[dmaDmemIdx] <= DmaWdata;
            end else begin
                imem[dmaImemIdx] <= DmaWdata;
            end
        end else if (storeWe) begin
            dmem[dataIdx] <= b_q;
        end
    end

endmodule

// File: tb/tb_mips_hold_core.sv
// Self-checking bench for mips_hold_core (DATA_W=32, 1024-word memories).
// Loads a program over the DMA port, runs it, checks retire timing and PC,
// then reads results back from data memory through the DMA port.
module tb_mips_hold_core;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        HOLD = 1'b0;
    logic        ACK;
    logic        DmaSel = 1'b0;
    logic        DmaWe = 1'b0;
    logic [9:0]  DmaAddr = '0;
    logic [31:0] DmaWdata = '0;
    logic [31:0] DmaRdata;
    logic [31:0] PcOut;
    logic        Retire;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sel;
        int          addr;
        logic [31:0] exp;
        string       name;
    } dmaVec_t;

    dmaVec_t     vecs[12];
    logic [31:0] prog[20];
    int          gapExp[24];
    int          retT[24];
    logic [31:0] retPc[24];

    mips_hold_core #(
        .DATA_W(32),
        .IMEM_DEPTH(1024),
        .DMEM_DEPTH(1024)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .HOLD(HOLD),
        .ACK(ACK),
        .DmaSel(DmaSel),
        .DmaWe(DmaWe),
        .DmaAddr(DmaAddr),
        .DmaWdata(DmaWdata),
        .DmaRdata(DmaRdata),
        .PcOut(PcOut),
        .Retire(Retire)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One DMA write; assumes ACK is already high.
    task automatic applyStimulus(input logic sel, input int addr, input logic [31:0] data);
        DmaSel   = sel;
        DmaAddr  = addr[9:0];
        DmaWdata = data;
        DmaWe    = 1'b1;
        tick();
        DmaWe    = 1'b0;
    endtask

    task automatic dmaRead(input logic sel, input int addr, output logic [31:0] data);
        DmaSel  = sel;
        DmaAddr = addr[9:0];
        #1;
        data = DmaRdata;
    endtask

    task automatic waitAck(input logic want, input int maxCyc, input string name);
        int took;
        took = 0;
        while (ACK !== want && took < maxCyc) begin
            tick();
            took++;
        end
        checkOutput(name, 64'(ACK), 64'(want));
    endtask

    initial begin
        logic [31:0] rd;
        int k;
        int nRet;

        // Program: loads, ALU ops, stores of results, lw/sw copy, NOPs, beq loop.
        prog[0]  = iType(6'd35, 5'd0, 5'd16, 16'd0);   // lw  $16,0($0)
        prog[1]  = iType(6'd35, 5'd0, 5'd17, 16'd4);   // lw  $17,4($0)
        prog[2]  = rType(5'd16, 5'd17, 5'd18, 6'd32);  // add $18
        prog[3]  = rType(5'd16, 5'd17, 5'd19, 6'd34);  // sub $19
        prog[4]  = rType(5'd16, 5'd17, 5'd20, 6'd36);  // and $20
        prog[5]  = rType(5'd16, 5'd17, 5'd21, 6'd37);  // or  $21
        prog[6]  = rType(5'd16, 5'd17, 5'd22, 6'd42);  // slt $22
        prog[7]  = iType(6'd43, 5'd0, 5'd18, 16'd32);  // sw  $18 -> dmem[8]
        prog[8]  = iType(6'd43, 5'd0, 5'd19, 16'd36);  // sw  $19 -> dmem[9]
        prog[9]  = iType(6'd43, 5'd0, 5'd20, 16'd40);  // sw  $20 -> dmem[10]
        prog[10] = iType(6'd43, 5'd0, 5'd21, 16'd44);  // sw  $21 -> dmem[11]
        prog[11] = iType(6'd43, 5'd0, 5'd22, 16'd48);  // sw  $22 -> dmem[12]
        prog[12] = iType(6'd35, 5'd0, 5'd8, 16'd12);   // lw  $8,12($0)
        prog[13] = iType(6'd43, 5'd0, 5'd8, 16'd16);   // sw  $8,16($0)
        prog[14] = rType(5'd16, 5'd17, 5'd23, 6'd33);  // unsupported funct: NOP
        prog[15] = rType(5'd16, 5'd17, 5'd0, 6'd32);   // add $0 (discarded)
        prog[16] = iType(6'd43, 5'd0, 5'd23, 16'd52);  // sw  $23 -> dmem[13]
        prog[17] = iType(6'd43, 5'd0, 5'd0, 16'd56);   // sw  $0  -> dmem[14]
        prog[18] = iType(6'd2, 5'd0, 5'd0, 16'd0);     // unsupported opcode: NOP
        prog[19] = iType(6'd4, 5'd0, 5'd0, 16'hFFFF);  // beq $0,$0,-1

        // Expected cycles between retires; first entry counts from release.
        gapExp = '{5, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, 4, 3, 4, 4, 4, 3, 3,
                   3, 3, 3, 3};

        vecs[0]  = '{1'b1, 8,  32'd11,         "add_result"};
        vecs[1]  = '{1'b1, 9,  32'hFFFF_FFFF,  "sub_result"};
        vecs[2]  = '{1'b1, 10, 32'd4,          "and_result"};
        vecs[3]  = '{1'b1, 11, 32'd7,          "or_result"};
        vecs[4]  = '{1'b1, 12, 32'd1,          "slt_result"};
        vecs[5]  = '{1'b1, 4,  32'h0000_00A5,  "lw_sw_copy"};
        vecs[6]  = '{1'b1, 3,  32'h0000_00A5,  "lw_source"};
        vecs[7]  = '{1'b1, 13, 32'd0,          "nop_funct_nowrite"};
        vecs[8]  = '{1'b1, 14, 32'd0,          "reg0_reads_zero"};
        vecs[9]  = '{1'b1, 20, 32'h0000_1111,  "entry_edge_write_ignored"};
        vecs[10] = '{1'b0, 0,  32'h8C10_0000,  "imem0_readback"};
        vecs[11] = '{1'b1, 1,  32'd6,          "dmem1_readback"};

        // Reset with HOLD already requested so nothing runs from empty imem.
        HOLD    = 1'b1;
        DmaSel  = 1'b1;
        #12;
        checkOutput("reset_ack", 64'(ACK), 64'd0);
        checkOutput("reset_pc", 64'(PcOut), 64'd0);
        checkOutput("reset_retire", 64'(Retire), 64'd0);
        checkOutput("reset_dmardata", 64'(DmaRdata), 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        tick();
        checkOutput("ack_first_edge", 64'(ACK), 64'd1);

        for (int i = 0; i < 20; i++) applyStimulus(1'b0, i, prog[i]);
        applyStimulus(1'b1, 0, 32'd5);
        applyStimulus(1'b1, 1, 32'd6);
        applyStimulus(1'b1, 3, 32'hA5);
        applyStimulus(1'b1, 4, 32'd0);
        applyStimulus(1'b1, 13, 32'h1234);
        applyStimulus(1'b1, 14, 32'h5678);
        applyStimulus(1'b1, 20, 32'h1111);

        // Release and record every retire until well into the beq loop.
        HOLD = 1'b0;
        tick();
        checkOutput("ack_falls", 64'(ACK), 64'd0);
        checkOutput("pc_after_release", 64'(PcOut), 64'd0);
        k = 0;
        nRet = 0;
        while (nRet < 24 && k < 400) begin
            tick();
            k++;
            if (Retire) begin
                retT[nRet]  = k;
                retPc[nRet] = PcOut;
                nRet++;
            end
        end
        checkOutput("retire_count", 64'(nRet), 64'd24);
        for (int i = 0; i < nRet; i++) begin
            checkOutput($sformatf("retire_gap_%0d", i),
                        64'((i == 0) ? retT[0] : retT[i] - retT[i-1]), 64'(gapExp[i]));
            checkOutput($sformatf("retire_pc_%0d", i), 64'(retPc[i]),
                        64'((i < 19) ? 4 * (i + 1) : 76));
        end

        // Request the bus with a write strobe already up; the entry edge
        // must not write because ACK was still low there.
        HOLD     = 1'b1;
        DmaSel   = 1'b1;
        DmaAddr  = 10'd20;
        DmaWdata = 32'hDEAD;
        DmaWe    = 1'b1;
        k = 0;
        while (!ACK && k < 10) begin
            tick();
            k++;
        end
        DmaWe = 1'b0;
        checkOutput("hold_in_loop_ack", 64'(ACK), 64'd1);
        checkOutput("held_pc", 64'(PcOut), 64'd76);
        tick(); tick(); tick();
        checkOutput("held_pc_frozen", 64'(PcOut), 64'd76);

        for (int i = 0; i < 12; i++) begin
            dmaRead(vecs[i].sel, vecs[i].addr, rd);
            checkOutput(vecs[i].name, 64'(rd), 64'(vecs[i].exp));
        end

        // New code at 76: add $24, then sw $24 -> dmem[15], then beq loop.
        applyStimulus(1'b0, 19, rType(5'd16, 5'd17, 5'd24, 6'd32));
        applyStimulus(1'b0, 20, iType(6'd43, 5'd0, 5'd24, 16'd60));
        applyStimulus(1'b0, 21, iType(6'd4, 5'd0, 5'd0, 16'hFFFF));

        // HOLD raised during DECODE of the add: add must finish first.
        HOLD = 1'b0;
        tick();                              // HELD -> FETCH
        checkOutput("rel2_ack", 64'(ACK), 64'd0);
        tick();                              // FETCH -> DECODE
        HOLD = 1'b1;
        tick();                              // -> EXEC
        tick();                              // -> WB
        tick();                              // -> FETCH, retire
        checkOutput("mid_hold_retire", 64'(Retire), 64'd1);
        checkOutput("mid_hold_ack_low", 64'(ACK), 64'd0);
        tick();                              // FETCH samples HOLD -> HELD
        checkOutput("mid_hold_ack_high", 64'(ACK), 64'd1);
        checkOutput("mid_hold_pc", 64'(PcOut), 64'd80);
        tick(); tick(); tick();
        checkOutput("mid_hold_pc_frozen", 64'(PcOut), 64'd80);

        HOLD = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        HOLD = 1'b1;
        waitAck(1'b1, 10, "rehold_ack");
        checkOutput("rehold_pc", 64'(PcOut), 64'd84);
        dmaRead(1'b1, 15, rd);
        checkOutput("mid_hold_wb_result", 64'(rd), 64'd11);

        // Reset during HELD with a DMA write pending.
        DmaSel   = 1'b1;
        DmaAddr  = 10'd8;
        DmaWdata = 32'hBAD;
        DmaWe    = 1'b1;
        @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        checkOutput("reset_held_ack", 64'(ACK), 64'd0);
        checkOutput("reset_held_pc", 64'(PcOut), 64'd0);
        @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
        DmaWe   = 1'b0;
        tick();
        checkOutput("post_reset_ack", 64'(ACK), 64'd1);
        dmaRead(1'b1, 8, rd);
        checkOutput("reset_write_discarded", 64'(rd), 64'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
